// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: walks FETCH..UPDATE for one instruction at a time,
// holds in WAIT on busy LSUs of active threads, advances the shared PC and stops on RET.
module core_sched_lane #(
  parameter int LANE    = 0,
  parameter int CW      = 3,
  parameter int PC_BITS = 8
) (
  input  logic [CW-1:0]      cnt,
  input  logic [1:0]         lsu,
  input  logic [PC_BITS-1:0] npc,
  input  logic [PC_BITS-1:0] pc0,
  output logic               busy,
  output logic               mism
);
  logic active;
  assign active = CW'(LANE) < cnt;
  assign busy   = active & ((lsu == 2'b01) | (lsu == 2'b10));
  assign mism   = active & (npc != pc0);
endmodule

module core_scheduler #(
  parameter int Threads_per_block = 4,
  parameter int pc_bits           = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(Threads_per_block+1)-1:0] thread_count,
  input  logic                                   fetch_done,
  input  logic                                   decoded_ret,
  input  logic [2*Threads_per_block-1:0]         lsu_state,
  input  logic [Threads_per_block*pc_bits-1:0]   next_pc,
  output logic [2:0]                             core_state,
  output logic [pc_bits-1:0]                     current_pc,
  output logic                                   done,
  output logic                                   diverge_err
);
  localparam int T  = Threads_per_block;
  localparam int CW = $clog2(T+1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [T-1:0]    busy, mism;

  // lane 0's mism is always 0, so |mism only flags disagreement with thread 0
  for (genvar i = 0; i < T; i++) begin : g_lane
    core_sched_lane #(.LANE(i), .CW(CW), .PC_BITS(pc_bits)) u_lane (
      .cnt  (cnt_q),
      .lsu  (lsu_state[2*i +: 2]),
      .npc  (next_pc[i*pc_bits +: pc_bits]),
      .pc0  (next_pc[0 +: pc_bits]),
      .busy (busy[i]),
      .mism (mism[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      current_pc  <= '0;
      diverge_err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt_q      <= thread_count;
        current_pc <= '0;
      end
      if (state == S_UPDATE && !decoded_ret) begin
        current_pc <= next_pc[0 +: pc_bits];
        if (|mism) diverge_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    state_nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:   state_nxt = fetch_done ? S_DECODE : S_FETCH;
      S_DECODE:  state_nxt = S_REQUEST;
      S_REQUEST: state_nxt = S_WAIT;
      S_WAIT:    state_nxt = (|busy) ? S_WAIT : S_EXECUTE;
      S_EXECUTE: state_nxt = S_UPDATE;
      S_UPDATE:  state_nxt = decoded_ret ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_state = state;
    done       = (state == S_DONE);
  end
endmodule
